// File: rtl/irda_pkg.sv
// Shared definitions for the IrDA transmit path: scheduler state encoding,
// NEC timing constants at 50 MHz and a grant-index width helper.
package irda_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4
   } sched_state_t;

   // NEC frame timing in 50 MHz clock cycles
   localparam int unsigned NEC_GUIDE_HIGH = 450000;
   localparam int unsigned NEC_GUIDE_LOW  = 225000;
   localparam int unsigned NEC_PULSE      = 28125;
   localparam int unsigned NEC_GAP0       = 28125;
   localparam int unsigned NEC_GAP1       = 84375;
   localparam int unsigned NEC_FRAME_GAP  = 2000000;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/irda_rr_arbiter.sv
// Combinational round-robin picker: first asserted request scanning upward
// from the slot after the last grant, wrapping around.
module irda_rr_arbiter
   import irda_pkg::*;
#(
   parameter  int unsigned N_REQ = 2,
   localparam int unsigned IW    = id_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last,
   output logic [IW-1:0]    grant,
   output logic             valid
);

   logic [IW-1:0] idx;

   // Scan from the farthest slot inward so the nearest hit is written last.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = IW'((int'(last) + k) % int'(N_REQ));
         if (req[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irda_tx_scheduler.sv
// Round-robin scheduler sharing one NEC IrDA transmitter between requesters.
// Define IRDA_SCHED_TIMEOUT_EN to abort WAIT_BUSY after BUSY_TIMEOUT cycles.
//
// state        | meaning
// IDLE         | waiting for a request while the transmitter is idle
// LAUNCH       | frame latched, oTX_START held high
// WAIT_BUSY    | waiting for the transmitter to raise busy
// WAIT_DONE    | frame on air, waiting for busy to fall
// GAP          | enforcing the inter-frame gap
module irda_tx_scheduler
   import irda_pkg::*;
#(
   parameter  int unsigned N_REQ        = 2,
   parameter  int unsigned START_CYCLES = 4,
   parameter  int unsigned GAP_CYCLES   = NEC_FRAME_GAP,
   parameter  int unsigned BUSY_TIMEOUT = 256,
   localparam int unsigned IW           = id_width(N_REQ)
) (
   input  logic                 iCLK,
   input  logic                 iRST,
   input  logic [N_REQ-1:0]     iREQ,
   input  logic [32*N_REQ-1:0]  iREQ_DATA,
   output logic [N_REQ-1:0]     oACK,
   output logic [N_REQ-1:0]     oDONE,
   output logic [IW-1:0]        oGRANT_ID,
   output logic                 oSCHED_BUSY,
   output logic [31:0]          oTX_DATA,
   output logic                 oTX_START,
   input  logic                 iTX_BUSY,
   output logic                 oERR
);

   localparam int unsigned TMR_MAX = (GAP_CYCLES > START_CYCLES) ? GAP_CYCLES : START_CYCLES;
   localparam int unsigned TW      = $clog2(TMR_MAX + 1);

   sched_state_t     state, state_nxt;
   logic [TW-1:0]    tmr, tmr_nxt;
   logic [IW-1:0]    ptr, ptr_nxt;
   logic [IW-1:0]    gid_nxt;
   logic [31:0]      data_nxt;
   logic [N_REQ-1:0] ack_nxt, done_nxt;
   logic             start_nxt;
   logic [IW-1:0]    arb_grant;
   logic             arb_valid;

`ifdef IRDA_SCHED_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(BUSY_TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt, to_nxt;
   logic            err_q, err_nxt;
`else
   logic unused_timeout;
   assign unused_timeout = ^BUSY_TIMEOUT;
`endif

   irda_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req   (iREQ),
      .last  (ptr),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   assign oSCHED_BUSY = (state != ST_IDLE);

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state     <= ST_IDLE;
         tmr       <= '0;
         ptr       <= IW'(N_REQ - 1);
         oGRANT_ID <= '0;
         oTX_DATA  <= '0;
         oACK      <= '0;
         oDONE     <= '0;
         oTX_START <= 1'b0;
      end else begin
         state     <= state_nxt;
         tmr       <= tmr_nxt;
         ptr       <= ptr_nxt;
         oGRANT_ID <= gid_nxt;
         oTX_DATA  <= data_nxt;
         oACK      <= ack_nxt;
         oDONE     <= done_nxt;
         oTX_START <= start_nxt;
      end
   end

`ifdef IRDA_SCHED_TIMEOUT_EN
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         to_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         to_cnt <= to_nxt;
         err_q  <= err_nxt;
      end
   end
   assign oERR = err_q;
`else
   assign oERR = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      ptr_nxt   = ptr;
      gid_nxt   = oGRANT_ID;
      data_nxt  = oTX_DATA;
      ack_nxt   = '0;
      done_nxt  = '0;
      start_nxt = 1'b0;
`ifdef IRDA_SCHED_TIMEOUT_EN
      to_nxt    = to_cnt;
      err_nxt   = 1'b0;
`endif
      case (state)
         // never grant into a transmitter that is still finishing a frame
         ST_IDLE: begin
            if (arb_valid && !iTX_BUSY) begin
               state_nxt          = ST_LAUNCH;
               data_nxt           = iREQ_DATA[32*int'(arb_grant) +: 32];
               ack_nxt[arb_grant] = 1'b1;
               gid_nxt            = arb_grant;
               ptr_nxt            = arb_grant;
               start_nxt          = 1'b1;
               tmr_nxt            = TW'(START_CYCLES - 1);
            end
         end
         ST_LAUNCH: begin
            if (tmr == '0) begin
               state_nxt = ST_WAIT_BUSY;
`ifdef IRDA_SCHED_TIMEOUT_EN
               to_nxt    = TO_W'(BUSY_TIMEOUT - 1);
`endif
            end else begin
               tmr_nxt   = tmr - TW'(1);
               start_nxt = 1'b1;
            end
         end
         ST_WAIT_BUSY: begin
            if (iTX_BUSY) begin
               state_nxt = ST_WAIT_DONE;
`ifdef IRDA_SCHED_TIMEOUT_EN
            end else if (to_cnt == '0) begin
               err_nxt             = 1'b1;
               done_nxt[oGRANT_ID] = 1'b1;
               state_nxt           = ST_GAP;
               tmr_nxt             = TW'(GAP_CYCLES);
            end else begin
               to_nxt = to_cnt - TO_W'(1);
`endif
            end
         end
         ST_WAIT_DONE: begin
            if (!iTX_BUSY) begin
               done_nxt[oGRANT_ID] = 1'b1;
               state_nxt           = ST_GAP;
               tmr_nxt             = TW'(GAP_CYCLES);
            end
         end
         ST_GAP: begin
            if (tmr == '0) state_nxt = ST_IDLE;
            else           tmr_nxt   = tmr - TW'(1);
         end
         default: begin
            state_nxt = ST_IDLE;
            tmr_nxt   = '0;
            ptr_nxt   = IW'(N_REQ - 1);
            gid_nxt   = '0;
            data_nxt  = '0;
`ifdef IRDA_SCHED_TIMEOUT_EN
            to_nxt    = '0;
`endif
         end
      endcase
   end

endmodule

// File: tb/tb_irda_tx_scheduler.sv
// Self-checking bench for irda_tx_scheduler with a behavioural transmitter
// and a cycle-arithmetic reference; IRDA_SCHED_TIMEOUT_EN selects timeout checks.
module tb_irda_tx_scheduler;

   localparam int N_REQ = 2;
   localparam int START = 4;
   localparam int GAP   = 100;
   localparam int BTO   = 256;
   // busy rises 3 cycles after start, lasts 50; oDONE follows the fall by one cycle
   localparam int DONE_OFS = 3 + 50 + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [63:0] req_data;
   logic [1:0]  ack, done;
   logic [0:0]  gid;
   logic        sbusy, tx_start, err;
   logic [31:0] tx_data;
   logic        tx_busy = 1'b0;

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;
   bit tx_respond = 1'b1;
   int rise_cyc = -1000;
   logic start_q = 1'b0;

   irda_tx_scheduler #(
      .N_REQ(N_REQ), .START_CYCLES(START), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(BTO)
   ) dut (
      .iCLK(clk), .iRST(rst), .iREQ(req), .iREQ_DATA(req_data),
      .oACK(ack), .oDONE(done), .oGRANT_ID(gid), .oSCHED_BUSY(sbusy),
      .oTX_DATA(tx_data), .oTX_START(tx_start), .iTX_BUSY(tx_busy), .oERR(err)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // transmitter model, evaluated away from the active edge
   always @(negedge clk) begin
      if (tx_start && !start_q && tx_respond) rise_cyc = cyc;
      start_q = tx_start;
      tx_busy = (cyc >= rise_cyc + 3) && (cyc < rise_cyc + 53);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic int rr_pick(input logic [1:0] r, input int lst);
      for (int k = 1; k <= N_REQ; k++)
         if (r[(lst + k) % N_REQ]) return (lst + k) % N_REQ;
      return -1;
   endfunction

   task automatic wait_start(output int s, output bit ok);
      ok = 1'b0;
      s  = -1;
      for (int i = 0; i < 400; i++) begin
         if (tx_start) begin
            ok = 1'b1;
            s  = cyc;
            break;
         end
         tick();
      end
      if (!ok) check_eq("start_seen", 0, 1);
   endtask

   task automatic expect_frame(input int id, input logic [31:0] data, input int exp_start,
                               input bit drop, input logic [1:0] wmask, output int d);
      int s, n_hi, bad_hold, extra_ack, n_err;
      bit ok, seen_done;
      d = -1;
      wait_start(s, ok);
      if (!ok) return;
      if (exp_start >= 0) check_eq("start_cycle", s, exp_start);
      check_eq("ack_vec", ack, 32'(1) << id);
      check_eq("grant_id", gid, id);
      check_eq("tx_data", tx_data, data);
      check_eq("sched_busy", sbusy, 1);
      if (drop) req[id] = 1'b0;
      req_data[32*id +: 32] = $urandom();
      n_hi = 0; bad_hold = 0; extra_ack = 0; n_err = 0; seen_done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (tx_start) n_hi++;
         if (i > 0 && ack != 2'b00) extra_ack++;
         if (tx_data !== data) bad_hold++;
         if (err) n_err++;
         if (cyc == s + 20) req = req | wmask;
         if (cyc == s + 21) req = req & ~wmask;
         if (done != 2'b00) begin
            seen_done = 1'b1;
            d = cyc;
            break;
         end
         tick();
      end
      check_eq("start_len", n_hi, START);
      check_eq("data_held", bad_hold, 0);
      check_eq("single_ack", extra_ack, 0);
      check_eq("no_err", n_err, 0);
      check_eq("done_seen", seen_done, 1);
      if (seen_done) begin
         check_eq("done_vec", done, 32'(1) << id);
         check_eq("done_cycle", d, s + DONE_OFS);
         tick();
         check_eq("done_len", done, 0);
         check_eq("data_retained", tx_data, data);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int d, s, last, id, stray, e_first, e_cnt, d_first, d_cnt;
      logic [1:0] nb, d_vec;
      logic [31:0] dat;
      bit ok, busy_a, busy_b;

      rst = 1'b1; req = '0; req_data = '0;
      repeat (5) tick();
      check_eq("rst_ack", ack, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_gid", gid, 0);
      check_eq("rst_sbusy", sbusy, 0);
      check_eq("rst_data", tx_data, 0);
      check_eq("rst_start", tx_start, 0);
      check_eq("rst_err", err, 0);
      rst = 1'b0;
      tick();
      last = N_REQ - 1;

      // single request, then an immediate re-request measures the gap
      req_data[31:0] = 32'h00FF_20DF;
      req = 2'b01;
      expect_frame(0, 32'h00FF_20DF, cyc + 1, 1'b1, 2'b00, d);
      last = 0;
      req_data[31:0] = $urandom();
      req = 2'b01;
      id = rr_pick(req, last);
      expect_frame(id, req_data[32*id +: 32], d + GAP + 2, 1'b1, 2'b00, d);
      last = id;

      // simultaneous requests after reset, both held: alternating service
      do_reset();
      last = N_REQ - 1;
      req_data = {$urandom(), $urandom()};
      req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         id = rr_pick(req, last);
         expect_frame(id, req_data[32*id +: 32], (k == 0) ? cyc + 1 : d + GAP + 2,
                      1'b0, 2'b00, d);
         last = id;
      end
      req = 2'b00;

      // requester 1 pulses for one cycle while requester 0 is on air
      req_data[31:0] = $urandom();
      req = 2'b01;
      id = rr_pick(req, last);
      expect_frame(id, req_data[32*id +: 32], d + GAP + 2, 1'b1, 2'b10, d);
      last = id;
      stray = 0;
      for (int i = 0; i < GAP + 20; i++) begin
         if (ack != 2'b00 || done != 2'b00) stray++;
         tick();
      end
      check_eq("withdraw_stray", stray, 0);
      check_eq("withdraw_idle", sbusy, 0);

      // randomized request patterns
      for (int it = 0; it < 6; it++) begin
         nb = 2'($urandom_range(0, 3)) & ~req;
         if ((req | nb) == 2'b00) nb = 2'($urandom_range(1, 3));
         for (int b = 0; b < N_REQ; b++)
            if (nb[b]) req_data[32*b +: 32] = $urandom();
         req = req | nb;
         id = rr_pick(req, last);
         expect_frame(id, req_data[32*id +: 32], (it == 0) ? cyc + 1 : d + GAP + 2,
                      1'b1, 2'b00, d);
         last = id;
      end
      req = 2'b00;
      repeat (GAP + 10) tick();

      // reset during WAIT_DONE with requester 1 pending
      req_data[31:0] = $urandom();
      req = 2'b01;
      wait_start(s, ok);
      if (ok) begin
         req[0] = 1'b0;
         while (cyc < s + 20) tick();
         req_data[63:32] = $urandom();
         dat = req_data[63:32];
         req = 2'b10;
         rst = 1'b1;
         tick();
         check_eq("mid_rst_sbusy", sbusy, 0);
         check_eq("mid_rst_start", tx_start, 0);
         check_eq("mid_rst_data", tx_data, 0);
         check_eq("mid_rst_gid", gid, 0);
         check_eq("mid_rst_ack", ack, 0);
         check_eq("mid_rst_done", done, 0);
         rst = 1'b0;
         stray = 0;
         while (cyc < s + 53) begin
            tick();
            if (tx_start || done != 2'b00 || ack != 2'b00) stray++;
         end
         check_eq("mid_rst_hold", stray, 0);
         last = N_REQ - 1;
         id = rr_pick(req, last);
         expect_frame(id, dat, s + 54, 1'b1, 2'b00, d);
         last = id;
      end

      // transmitter never answers
      tx_respond = 1'b0;
      req_data[31:0] = $urandom();
      req = 2'b01;
      wait_start(s, ok);
      if (ok) begin
         req[0] = 1'b0;
         e_first = -1; e_cnt = 0; d_first = -1; d_cnt = 0; d_vec = '0;
         busy_a = 1'b0; busy_b = 1'b0;
         while (cyc <= s + 400) begin
            if (err) begin
               e_cnt++;
               if (e_first < 0) e_first = cyc;
            end
            if (done != 2'b00) begin
               d_cnt++;
               if (d_first < 0) begin
                  d_first = cyc;
                  d_vec = done;
               end
            end
            if (cyc == s + 4 + BTO + GAP)     busy_a = sbusy;
            if (cyc == s + 4 + BTO + GAP + 1) busy_b = sbusy;
            tick();
         end
`ifdef IRDA_SCHED_TIMEOUT_EN
         check_eq("to_err_cycle", e_first, s + 4 + BTO);
         check_eq("to_err_count", e_cnt, 1);
         check_eq("to_done_cycle", d_first, s + 4 + BTO);
         check_eq("to_done_vec", d_vec, 2'b01);
         check_eq("to_gap_busy", busy_a, 1);
         check_eq("to_back_idle", busy_b, 0);
`else
         check_eq("wait_no_err", e_cnt, 0);
         check_eq("wait_no_done", d_cnt, 0);
         check_eq("wait_still_busy", sbusy, 1);
`endif
      end
      tx_respond = 1'b1;
      do_reset();
      check_eq("final_idle", sbusy, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/irda_tx_scheduler.md
Name: irda_tx_scheduler

Overview:
Shares the single NEC-style IrDA transmitter between N_REQ requesters, such as the CPU MMIO port and a remote-repeat generator. It arbitrates round-robin and latches the winning 32-bit frame. It then sequences the transmitter: start pulse, wait for busy to rise, wait for busy to fall. Finally it enforces a minimum inter-frame gap before the next grant. It sits between the requesters and the transmitter's iDATA/iTXD_READY/oTXD_BUSY pins.

Parameters:
N_REQ, 2, number of requesters (2..8).
START_CYCLES, 4, cycles oTX_START is held high per launch.
GAP_CYCLES, 2000000, idle cycles enforced after each frame (40 ms at 50 MHz).
BUSY_TIMEOUT, 256, max cycles to wait for iTX_BUSY to rise (optional feature only).

Ports:
iCLK  in  1  system clock, 50 MHz
iRST  in  1  synchronous reset, active-high
iREQ  in  N_REQ  per-requester frame request; level, held until oACK
iREQ_DATA  in  32*N_REQ  packed frames; requester i at bits [32i+31:32i]
oACK  out  N_REQ  one-cycle pulse: frame of requester i latched
oDONE  out  N_REQ  one-cycle pulse: requester i's frame finished
oGRANT_ID  out  max(1,clog2(N_REQ))  index of current/last granted requester
oSCHED_BUSY  out  1  high in any state other than IDLE
oTX_DATA  out  32  frame to transmitter iDATA
oTX_START  out  1  to transmitter iTXD_READY
iTX_BUSY  in  1  from transmitter oTXD_BUSY
oERR  out  1  one-cycle pulse on busy-rise timeout (optional feature)

Behaviour:
- One clock domain and a synchronous active-high reset, iRST.
- Reset values: state IDLE; all outputs 0; last-grant pointer = N_REQ-1, so requester 0 wins first; all counters 0.
- **IDLE**
  - Grants only when some iREQ bit is 1 and iTX_BUSY==0.
  - If iTX_BUSY is high after reset, the block waits; it never aborts the transmitter.
  - Winner is the first asserted iREQ bit scanning from (last+1) mod N_REQ upward, with wrap-around.
  - Requests that appear in the same cycle are resolved purely by this scan.
- **Grant cycle t (registered)**
  - At t+1: state LAUNCH, oTX_DATA = winner's frame, oACK[g]=1 for exactly one cycle, oGRANT_ID=g, oTX_START=1, pointer=g.
- **LAUNCH**
  - oTX_START stays high for START_CYCLES cycles total, then drops.
  - Next state is WAIT_BUSY.
- **WAIT_BUSY**
  - Holds until iTX_BUSY==1, then moves to WAIT_DONE.
  - If iTX_BUSY is already 1 on entry, moves next cycle.
- **WAIT_DONE**
  - Holds until iTX_BUSY==0.
  - On exit, oDONE[g]=1 for one cycle and the next state is GAP.
- **GAP**
  - Counts GAP_CYCLES cycles, then returns to IDLE.
  - The earliest next oTX_START rise is GAP_CYCLES+2 cycles after oDONE.
- oTX_DATA is stable from LAUNCH through WAIT_DONE, because the transmitter indexes iDATA bitwise during the frame. It retains its value in GAP and IDLE.
- iREQ deasserted before oACK withdraws the request with no side effects. iREQ/iREQ_DATA changes after oACK are ignored until the next grant.
- A requester still holding iREQ in IDLE after its own oDONE is treated as a new request.
- Counter widths are clog2(max count+1); counters saturate, they do not wrap.
- iRST mid-frame: immediate return to reset values with no oDONE, and the transmitter finishes on its own. IDLE then waits for iTX_BUSY==0 before the next grant.
- Unused or illegal state encodings go to IDLE with outputs cleared.

Optional Feature:
Macro IRDA_SCHED_TIMEOUT_EN.
- With it: WAIT_BUSY counts cycles. If iTX_BUSY has not risen after BUSY_TIMEOUT cycles, oERR and oDONE[g] pulse together for one cycle and the state goes to GAP.
- Without it: WAIT_BUSY waits indefinitely, oERR is tied to 0, and no timeout counter is built.

Decomposition:
- Shared package irda_pkg holds:
  - the scheduler state encoding (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP);
  - NEC timing constants at 50 MHz (guide 450000/225000, pulse 28125, gap0 28125, gap1 84375, frame gap 2000000).
- One sub-module, irda_rr_arbiter: combinational round-robin picker; inputs request vector and last-grant pointer, outputs grant index and valid.

Test Plan:
Bench uses GAP_CYCLES=100 and START_CYCLES=4. The transmitter model raises busy 3 cycles after oTX_START rises and holds it 50 cycles.
- Single request: iREQ=01, data0=32'h00FF_20DF → oACK=01 at t+1; oTX_START high 4 cycles; oTX_DATA=32'h00FF_20DF held until oDONE=01; next grant no sooner than 102 cycles after oDONE.
- Simultaneous requests after reset: iREQ=11 → requester 0 first, then 1. With both held continuously, grants alternate 0,1,0,1.
- Withdrawal: iREQ[1] pulsed 1 cycle while requester 0's frame is in flight → no oACK[1], no oDONE[1].
- Reset mid-WAIT_DONE with model busy still high → outputs 0 at once. A pending request is not granted until busy falls.
- With IRDA_SCHED_TIMEOUT_EN, model never raises busy → oERR and oDONE pulse exactly BUSY_TIMEOUT cycles into WAIT_BUSY, then GAP, then IDLE. Without the macro, the block remains in WAIT_BUSY.
